// File: rtl/fifo_pkg.sv
// Shared FIFO sizing helpers.
// Pointer width and depth derivation from the address width.
package fifo_pkg;

  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sync_counter.sv
// Free-running enable counter.
// Async active-low reset plus a synchronous reset input.
module sync_counter #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sync_rst,
  input  logic                  i_enable,
  output logic [DATA_WIDTH-1:0] o_count
);

  // count up on enable, sync reset wins over enable
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_count <= '0;
    end else if (i_sync_rst) begin
      o_count <= '0;
    end else if (i_enable) begin
      o_count <= o_count + DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer and flag controller.
// Accepts transfers against registered flags, tracks fill and errors.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH          = 4,
  parameter int ALMOST_FULL_THRESH  = (2**ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_wr_req,
  input  logic                  i_rd_req,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_fill,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  localparam logic [PW-1:0] DEPTH_V =
    PW'(fifo_depth(ADDR_WIDTH));
  localparam logic [PW-1:0] AF_V =
    PW'(ALMOST_FULL_THRESH);
  localparam logic [PW-1:0] AE_V =
    PW'(ALMOST_EMPTY_THRESH);

  logic          wr_acc;
  logic          rd_acc;
  logic          wr_srst;
  logic          rd_srst;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] fill_q;
  logic [PW-1:0] fill_nxt;
  logic          full_q;
  logic          empty_q;
  logic          af_q;
  logic          ae_q;
  logic          ovf_q;
  logic          unf_q;
  logic          ovf_nxt;
  logic          unf_nxt;

  // strobes are gated by reset so they drop asynchronously
  assign wr_acc = i_rst & i_wr_req & ~full_q & ~i_clear;
  assign rd_acc = i_rst & i_rd_req & ~empty_q & ~i_clear;

  // flush folds into the counters' synchronous reset path
  assign wr_srst = i_clear ? 1'b1 : 1'b0;
  assign rd_srst = i_clear ? 1'b1 : 1'b0;

  sync_counter #(
    .DATA_WIDTH (PW)
  ) u_wr_ptr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sync_rst (wr_srst),
    .i_enable   (wr_acc),
    .o_count    (wr_ptr)
  );

  sync_counter #(
    .DATA_WIDTH (PW)
  ) u_rd_ptr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sync_rst (rd_srst),
    .i_enable   (rd_acc),
    .o_count    (rd_ptr)
  );

  // next fill and sticky error state
  always_comb begin
    fill_nxt = fill_q;
    ovf_nxt  = ovf_q | (i_wr_req & full_q);
    unf_nxt  = unf_q | (i_rd_req & empty_q);
    unique case (1'b1)
      i_clear: begin
        fill_nxt = '0;
        ovf_nxt  = 1'b0;
        unf_nxt  = 1'b0;
      end
      (wr_acc & ~rd_acc): fill_nxt = fill_q + PW'(1);
      (rd_acc & ~wr_acc): fill_nxt = fill_q - PW'(1);
      default: ;
    endcase
  end

  // fill and flags registered together from the next fill
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fill_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      fill_q  <= fill_nxt;
      full_q  <= (fill_nxt == DEPTH_V);
      empty_q <= (fill_nxt == '0);
      af_q    <= (fill_nxt >= AF_V);
      ae_q    <= (fill_nxt <= AE_V);
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  assign o_wr_en        = wr_acc;
  assign o_rd_en        = rd_acc;
  assign o_wr_addr      = wr_ptr[ADDR_WIDTH-1:0];
  assign o_rd_addr      = rd_ptr[ADDR_WIDTH-1:0];
  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_almost_full  = af_q;
  assign o_almost_empty = ae_q;
  assign o_fill         = fill_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl.
// DEPTH=4, almost-full at 3, almost-empty at 1.
module tb_fifo_ptr_ctrl;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       wr_req;
  logic       rd_req;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic       full;
  logic       empty;
  logic       afull;
  logic       aempty;
  logic [2:0] fill;
  logic       ovf;
  logic       unf;

  int checks;
  int fails;

  fifo_ptr_ctrl #(
    .ADDR_WIDTH          (2),
    .ALMOST_FULL_THRESH  (3),
    .ALMOST_EMPTY_THRESH (1)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_clear        (clear),
    .i_wr_req       (wr_req),
    .i_rd_req       (rd_req),
    .o_wr_en        (wr_en),
    .o_wr_addr      (wr_addr),
    .o_rd_en        (rd_en),
    .o_rd_addr      (rd_addr),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (afull),
    .o_almost_empty (aempty),
    .o_fill         (fill),
    .o_overflow     (ovf),
    .o_underflow    (unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag,
                           input int f);
    chk({tag, "_fill"}, 32'(fill), f);
    chk({tag, "_full"}, 32'(full), 32'(f == 4));
    chk({tag, "_empty"}, 32'(empty), 32'(f == 0));
    chk({tag, "_af"}, 32'(afull), 32'(f >= 3));
    chk({tag, "_ae"}, 32'(aempty), 32'(f <= 1));
  endtask

  task automatic do_wr(input string tag,
                       input int a);
    wr_req = 1'b1;
    rd_req = 1'b0;
    #1;
    chk({tag, "_wr_en"}, 32'(wr_en), 1);
    chk({tag, "_wr_addr"}, 32'(wr_addr), a);
    tick();
    wr_req = 1'b0;
  endtask

  task automatic do_rd(input string tag,
                       input int a);
    wr_req = 1'b0;
    rd_req = 1'b1;
    #1;
    chk({tag, "_rd_en"}, 32'(rd_en), 1);
    chk({tag, "_rd_addr"}, 32'(rd_addr), a);
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b0;
    clear  = 1'b0;
    wr_req = 1'b1;
    rd_req = 1'b1;

    // reset held three cycles with requests pending
    tick();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    tick();
    tick();
    rst    = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    #1;
    chk_flags("reset", 0);
    chk("reset_wa", 32'(wr_addr), 0);
    chk("reset_ra", 32'(rd_addr), 0);
    chk("reset_wr_en", 32'(wr_en), 0);
    chk("reset_rd_en", 32'(rd_en), 0);
    chk("reset_ovf", 32'(ovf), 0);
    chk("reset_unf", 32'(unf), 0);

    // fill to full
    for (int i = 0; i < 4; i++) begin
      do_wr("fill", i);
      chk_flags("fill", i + 1);
    end

    // write while full
    wr_req = 1'b1;
    #1;
    chk("ovf_wr_en", 32'(wr_en), 0);
    tick();
    wr_req = 1'b0;
    chk("ovf_fill", 32'(fill), 4);
    chk("ovf_set", 32'(ovf), 1);

    // drain, refill across the wrap, drain again
    for (int i = 0; i < 4; i++) begin
      do_rd("drain1", i);
      chk_flags("drain1", 3 - i);
    end
    for (int i = 0; i < 4; i++) begin
      do_wr("wrap", i);
      chk_flags("wrap", i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      do_rd("drain2", i);
      chk_flags("drain2", 3 - i);
    end
    chk("drain_unf", 32'(unf), 0);

    // flush with nothing pending clears overflow
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr0_ovf", 32'(ovf), 0);
    chk_flags("clr0", 0);

    // both requests while empty
    wr_req = 1'b1;
    rd_req = 1'b1;
    #1;
    chk("emp_wr_en", 32'(wr_en), 1);
    chk("emp_rd_en", 32'(rd_en), 0);
    tick();
    chk_flags("emp", 1);
    chk("emp_unf", 32'(unf), 1);
    chk("emp_ovf", 32'(ovf), 0);

    // both requests at fill=2
    do_wr("mid_pre", 1);
    wr_req = 1'b1;
    rd_req = 1'b1;
    #1;
    chk("mid_wr_en", 32'(wr_en), 1);
    chk("mid_rd_en", 32'(rd_en), 1);
    chk("mid_wa", 32'(wr_addr), 2);
    chk("mid_ra", 32'(rd_addr), 0);
    tick();
    chk_flags("mid", 2);

    // both requests while full
    do_wr("full_pre", 3);
    do_wr("full_pre", 0);
    chk_flags("full_pre", 4);
    wr_req = 1'b1;
    rd_req = 1'b1;
    #1;
    chk("full_wr_en", 32'(wr_en), 0);
    chk("full_rd_en", 32'(rd_en), 1);
    tick();
    chk_flags("full", 3);
    chk("full_ovf", 32'(ovf), 1);

    // flush with a write pending
    clear  = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b0;
    #1;
    chk("clr_wr_en", 32'(wr_en), 0);
    chk("clr_rd_en", 32'(rd_en), 0);
    tick();
    clear  = 1'b0;
    wr_req = 1'b0;
    chk_flags("clr", 0);
    chk("clr_ovf", 32'(ovf), 0);
    chk("clr_unf", 32'(unf), 0);
    chk("clr_wa", 32'(wr_addr), 0);
    chk("clr_ra", 32'(rd_addr), 0);

    // async reset between edges at fill=2
    do_wr("ar_pre", 0);
    do_wr("ar_pre", 1);
    wr_req = 1'b1;
    rd_req = 1'b1;
    #1;
    chk("ar_wr_en_pre", 32'(wr_en), 1);
    chk("ar_rd_en_pre", 32'(rd_en), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_wr_en", 32'(wr_en), 0);
    chk("ar_rd_en", 32'(rd_en), 0);
    chk_flags("ar", 0);
    chk("ar_wa", 32'(wr_addr), 0);
    chk("ar_ra", 32'(rd_addr), 0);
    tick();
    rst    = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    tick();
    chk_flags("ar_post", 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
